// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter
//   Shares one WIDTH-bit register between NREQ write requesters using
//   round-robin arbitration. At most one write lands per clock. A granted
//   requester may lock the register for a burst. The lock is forcibly released
//   after LOCK_MAX locked cycles.
//
//   Optional feature macro: RR_WRITE_ARB_PRIO0_EN
//     When defined, requester 0 has strict priority in IDLE and its grants leave
//     the round-robin pointer unchanged. While LOCKED it waits like the others.
//
// Ports
//   clk          clock; all state updates on posedge
//   rstn         asynchronous active-low reset
//   req          per-requester write request
//   lock         per-requester lock request (meaningful only with req)
//   wdata        packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt          registered one-hot write acknowledge
//   q            shared register contents
//   q_valid      sticky, set by the first write after reset
//   owner        index of the last writer
//   locked       high while the register is locked
//   lock_timeout one-cycle pulse on a forced lock release
module rr_reg_write_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_MAX = 16,
    localparam int unsigned OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [OW-1:0]         owner,
    output logic                  locked,
    output logic                  lock_timeout
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // Round-robin winner, scanning ptr, ptr+1, ... with wrap-around.
    logic [2*NREQ-1:0] req_dbl;
    logic              rr_valid;
    logic [OW-1:0]     rr_idx;

    assign req_dbl = {req, req};

    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!rr_valid && req_dbl[int'(ptr_q) + k]) begin
                rr_valid = 1'b1;
                rr_idx   = OW'((int'(ptr_q) + k) % int'(NREQ));
            end
        end
    end

    logic          win_valid;
    logic [OW-1:0] win_idx;
    logic          prio_hit;

`ifdef RR_WRITE_ARB_PRIO0_EN
    always_comb begin
        prio_hit  = req[0];
        win_valid = req[0] | rr_valid;
        win_idx   = req[0] ? '0 : rr_idx;
    end
`else
    always_comb begin
        prio_hit  = 1'b0;
        win_valid = rr_valid;
        win_idx   = rr_idx;
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        q_d     = q_q;
        valid_d = valid_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;

        if (state_q == StIdle) begin
            if (win_valid) begin
                q_d            = wdata[int'(win_idx)*WIDTH +: WIDTH];
                owner_d        = win_idx;
                valid_d        = 1'b1;
                gnt_d[win_idx] = 1'b1;
                // Priority-0 grants do not advance the round-robin pointer.
                if (!prio_hit) begin
                    ptr_d = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + OW'(1);
                end
                if (lock[win_idx]) begin
                    state_d = StLocked;
                    cnt_d   = CntW'(1);
                end
            end
        end else begin
            // Only the lock owner is served; the owner's write is honoured even
            // on the releasing edge.
            if (req[owner_q]) begin
                q_d            = wdata[int'(owner_q)*WIDTH +: WIDTH];
                gnt_d[owner_q] = 1'b1;
            end
            if (!lock[owner_q]) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if (cnt_q == CntW'(LOCK_MAX)) begin
                state_d = StIdle;
                cnt_d   = '0;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt          = gnt_q;
    assign q            = q_q;
    assign q_valid      = valid_q;
    assign owner        = owner_q;
    assign locked       = (state_q == StLocked);
    assign lock_timeout = tmo_q;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
module tb_rr_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 16;
    localparam int OW       = 2;

    logic                  clk;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [OW-1:0]         owner;
    logic                  locked;
    logic                  lock_timeout;

    rr_reg_write_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .lock        (lock),
        .wdata       (wdata),
        .gnt         (gnt),
        .q           (q),
        .q_valid     (q_valid),
        .owner       (owner),
        .locked      (locked),
        .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: integers and a modulo scan from the pointer.
    int m_q, m_owner, m_ptr, m_cnt, m_gnt, m_to, m_valid, m_locked;
    int tmo_seen;

    task automatic model_reset();
        m_q = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_gnt = 0; m_to = 0; m_valid = 0; m_locked = 0;
    endtask

    function automatic int wd(input int i);
        return int'(wdata[i*WIDTH +: WIDTH]);
    endfunction

    task automatic model_edge();
        int win;
        bit prio;
        m_to = 0;
        if (m_locked != 0) begin
            m_gnt = 0;
            if (req[m_owner]) begin
                m_q   = wd(m_owner);
                m_gnt = 1 << m_owner;
            end
            if (!lock[m_owner]) begin
                m_locked = 0; m_cnt = 0;
            end else if (m_cnt == LOCK_MAX) begin
                m_locked = 0; m_cnt = 0; m_to = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            win  = -1;
            prio = 1'b0;
`ifdef RR_WRITE_ARB_PRIO0_EN
            if (req[0]) begin win = 0; prio = 1'b1; end
`endif
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            if (win >= 0) begin
                m_q     = wd(win);
                m_owner = win;
                m_valid = 1;
                m_gnt   = 1 << win;
                if (!prio) m_ptr = (win + 1) % NREQ;
                if (lock[win]) begin m_locked = 1; m_cnt = 1; end
            end else begin
                m_gnt = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".gnt"}, int'(gnt), m_gnt);
        chk({tag, ".q"}, int'(q), m_q);
        chk({tag, ".q_valid"}, int'(q_valid), m_valid);
        chk({tag, ".owner"}, int'(owner), m_owner);
        chk({tag, ".locked"}, int'(locked), m_locked);
        chk({tag, ".lock_timeout"}, int'(lock_timeout), m_to);
        if (lock_timeout) tmo_seen++;
    endtask

    // One clock: inputs are stable from the previous negedge, the model
    // advances at posedge and outputs are compared at the following negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic set_wdata_seq();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    endtask

    task automatic set_wdata_rand();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'($urandom_range(255));
    endtask

    initial begin
        int last_gnt;
        rstn = 1'b0; req = '0; lock = '0; wdata = '0;
        tmo_seen = 0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Full request vector, sequential round-robin order with fixed data.
        req = 4'b1111;
        set_wdata_seq();
        for (int i = 0; i < 4; i++) begin
            step("rr_all");
            chk("rr_all.gnt_const", int'(gnt), 1 << i);
            chk("rr_all.q_const", int'(q), 8'h10 + i);
        end

        // Move pointer to 3, then exercise wrap-around 3 -> 0.
        req = 4'b0100;
        step("ptr_to3");
        req = 4'b1001;
        step("wrap_a");
        chk("wrap_a.gnt_const", int'(gnt), 4'b1000);
        step("wrap_b");
        chk("wrap_b.gnt_const", int'(gnt), 4'b0001);

        // Lock by requester 1 while requester 2 waits.
        req = 4'b0110; lock = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            set_wdata_rand();
            step("lock1");
            chk("lock1.gnt_const", int'(gnt), 4'b0010);
            chk("lock1.locked_const", int'(locked), 1);
        end
        lock = 4'b0000;
        step("lock1_rel");
        step("after_rel");
        chk("after_rel.gnt_const", int'(gnt), 4'b0100);
        req = '0;
        step("idle");
        chk("idle.gnt_const", int'(gnt), 0);

        // Forced lock release: ptr lands on 2, requester 2 holds, 3 waits.
        req = 4'b0010;
        step("ptr_to2");
        req = 4'b1100; lock = 4'b0100;
        tmo_seen = 0;
        for (int i = 0; i < LOCK_MAX + 1; i++) begin
            set_wdata_rand();
            step("tmo");
        end
        chk("tmo.pulse_count", tmo_seen, 1);
        chk("tmo.locked_low", int'(locked), 0);
        step("tmo_next");
        chk("tmo_next.gnt_const", int'(gnt), 4'b1000);
        req = '0; lock = '0;
        step("tmo_idle");

        // Asynchronous reset in the middle of a lock.
        req = 4'b0001; lock = 4'b0001;
        step("pre_rst");
        step("pre_rst2");
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        req = 4'b1111; lock = '0;
        set_wdata_seq();
        step("post_rst");
        chk("post_rst.gnt_const", int'(gnt), 4'b0001);

        // Requesters 0 and 2 both held.
        req = 4'b0101;
        last_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            step("r0101");
`ifdef RR_WRITE_ARB_PRIO0_EN
            chk("r0101.prio0", int'(gnt), 4'b0001);
`else
            if (i > 0) chk("r0101.alt", int'(gnt), (last_gnt == 1) ? 4 : 1);
`endif
            last_gnt = int'(gnt);
        end

        // Random traffic against the model; locks are held most of the time.
        for (int i = 0; i < 300; i++) begin
            req  = 4'($urandom_range(15));
            lock = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom_range(15));
            set_wdata_rand();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
